// File: rtl/lsu_pkg.sv
// lsu_pkg: size codes, op bit positions, state encoding and misalignment helper for the load/store unit
package lsu_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam int OP_WRITE_BIT = 3;
   localparam int OP_UNSIGNED_BIT = 2;
   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      return size == SZ_BYTE ? 1'b0 : size == SZ_HALF ? off[0] : off != 2'b00;
   endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: request/response handshake plus word-organised data memory port of the load/store unit
interface lsu_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [3:0]            req_op;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  resp_valid;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_error;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [DATA_WIDTH-1:0] mem_write_data;
   logic                  mem_write_enable;
   logic                  mem_read_enable;
   logic [DATA_WIDTH-1:0] mem_read_data;
   modport master(
      input  req_valid, req_op, req_addr, req_wdata, mem_read_data,
      output req_ready, resp_valid, resp_rdata, resp_error,
             mem_address, mem_write_data, mem_write_enable, mem_read_enable
   );
   modport slave(
      output req_valid, req_op, req_addr, req_wdata, mem_read_data,
      input  req_ready, resp_valid, resp_rdata, resp_error,
             mem_address, mem_write_data, mem_write_enable, mem_read_enable
   );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: little-endian lane extraction/extension for loads and read-modify-write merge for sub-word stores
module lsu_align import lsu_pkg::*; (
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [1:0]  off,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);
   logic [4:0]  bsh;
   logic [4:0]  hsh;
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      bsh = {off, 3'b000};
      hsh = {off[1], 4'b0000};
      b = 8'(rdata >> bsh);
      h = 16'(rdata >> hsh);
      load_data = size == SZ_BYTE ? {{24{~uns & b[7]}}, b}
                : size == SZ_HALF ? {{16{~uns & h[15]}}, h} : rdata;
      merged = size == SZ_BYTE ? (rdata & ~(32'h0000_00FF << bsh)) | ({24'd0, wdata[7:0]} << bsh)
             : size == SZ_HALF ? (rdata & ~(32'h0000_FFFF << hsh)) | ({16'd0, wdata[15:0]} << hsh) : wdata;
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store sequencer for a combinational-read word memory.
// Define MISALIGN_TRAP_EN to return resp_error for misaligned half/word accesses instead of masking the low bits.
module load_store_unit import lsu_pkg::*; #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic clk,
   input logic rst_n,
   lsu_if.master bus
);
   state_t                state;
   logic [3:0]            op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] merged_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] load_data;
   logic [DATA_WIDTH-1:0] merged;
   logic                  err_q;
   logic                  mis;
   logic                  wr_op;
   logic                  sub;
   logic                  rd_en;
   logic                  wr_en;
   lsu_align u_align (
      .size(op_q[1:0]),
      .uns(op_q[OP_UNSIGNED_BIT]),
      .off(addr_q[1:0]),
      .rdata(bus.mem_read_data),
      .wdata(wdata_q),
      .load_data(load_data),
      .merged(merged)
   );
`ifdef MISALIGN_TRAP_EN
   assign mis = is_misaligned(op_q[1:0], addr_q[1:0]);
`else
   assign mis = 1'b0;
`endif
   // sub-word stores (size 00/01) need a read before the merged write
   always_comb begin
      wr_op = op_q[OP_WRITE_BIT];
      sub = wr_op && !op_q[1];
      rd_en = state == ACCESS && !mis && (!wr_op || sub);
      wr_en = (state == ACCESS && !mis && wr_op && !sub) || state == WRITE;
   end
   assign bus.req_ready = state == IDLE;
   assign bus.resp_valid = state == RESP;
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_error = err_q;
   assign bus.mem_read_enable = rd_en;
   assign bus.mem_write_enable = wr_en;
   assign bus.mem_address = rd_en || wr_en ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
   assign bus.mem_write_data = state == WRITE ? merged_q : wr_en ? wdata_q : '0;
   always_ff @(posedge clk)
      if (!rst_n) begin
         state <= IDLE;
         op_q <= '0;
         addr_q <= '0;
         wdata_q <= '0;
         merged_q <= '0;
         rdata_q <= '0;
         err_q <= 1'b0;
      end else
         case (state)
            IDLE: if (bus.req_valid) begin
               op_q <= bus.req_op;
               addr_q <= bus.req_addr;
               wdata_q <= bus.req_wdata;
               state <= ACCESS;
            end
            ACCESS: begin
               rdata_q <= wr_op || mis ? '0 : load_data;
               err_q <= mis;
               merged_q <= merged;
               state <= sub && !mis ? WRITE : RESP;
            end
            WRITE: state <= RESP;
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench for load_store_unit against a byte-addressed reference memory
`timescale 1ns/1ps
module tb_load_store_unit;
   typedef struct {
      logic [31:0] d;
      logic        e;
      int          due;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] mem [64];
   logic        init_we = 1'b0;
   logic [5:0]  init_idx = '0;
   logic [31:0] init_data = '0;
   logic [7:0]  ref_b [256];
   exp_t        q[$];
   exp_t        e;
   int          compared = 0;
   int          mismatched = 0;
   int          cyc = 0;
   int          n_rd = 0;
   int          n_wr = 0;
   logic [31:0] last_wa = '0;
   logic [31:0] last_wd = '0;
   always #5 clk = ~clk;
   lsu_if bus();
   load_store_unit dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );
   assign bus.mem_read_data = mem[bus.mem_address[7:2]];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (init_we) mem[init_idx] <= init_data;
      else if (bus.mem_write_enable === 1'b1) mem[bus.mem_address[7:2]] <= bus.mem_write_data;
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      compared++;
      if (act !== want) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", nm, act, want);
      end
   endtask
   initial forever begin
      @(negedge clk);
      if (bus.mem_read_enable === 1'b1) n_rd++;
      if (bus.mem_write_enable === 1'b1) begin
         n_wr++;
         last_wa = bus.mem_address;
         last_wd = bus.mem_write_data;
      end
      if (bus.mem_read_enable === 1'b1 || bus.mem_write_enable === 1'b1)
         chk("rd_wr_exclusive", {31'd0, bus.mem_read_enable & bus.mem_write_enable}, 32'd0);
      if (rst_n && bus.resp_valid === 1'b1) begin
         if (q.size() == 0) chk("unexpected_resp", {31'd0, bus.resp_valid}, 32'd0);
         else begin
            e = q.pop_front();
            compared++;
            if (bus.resp_rdata !== e.d || bus.resp_error !== e.e || cyc != e.due) begin
               mismatched++;
               $display("FAIL resp: rdata=%h err=%b cyc=%0d, expected rdata=%h err=%b cyc=%0d",
                        bus.resp_rdata, bus.resp_error, cyc, e.d, e.e, e.due);
            end
         end
      end
   end
   // reference: byte-addressed memory, accesses aligned down to their natural size
   task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [31:0] wd, input bit want);
      int n = 0;
      int sz;
      int base;
      int lat;
      logic [31:0] v = '0;
      logic err = 1'b0;
      @(negedge clk);
      while (bus.req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (bus.req_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL req_ready_timeout: got %b, expected 1", bus.req_ready);
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
         $fatal(1);
      end
      sz = op[1:0] == 2'b00 ? 1 : op[1:0] == 2'b01 ? 2 : 4;
      base = int'(a) - int'(a) % sz;
      lat = op[3] && sz < 4 ? 3 : 2;
`ifdef MISALIGN_TRAP_EN
      err = base != int'(a);
`endif
      if (err) lat = 2;
      else if (op[3]) for (int i = 0; i < sz; i++) ref_b[base + i] = wd[8*i +: 8];
      else begin
         for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_b[base + i];
         if (sz < 4 && !op[2] && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
      end
      bus.req_valid = 1'b1;
      bus.req_op = op;
      bus.req_addr = {24'd0, a};
      bus.req_wdata = wd;
      if (want) q.push_back('{d: v, e: err, due: cyc + lat});
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask
   task automatic drain;
      int n = 0;
      while (q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
         q.delete();
      end
   endtask
   initial begin
      int r0;
      int w0;
      int n;
      logic [31:0] w;
      logic [31:0] rnd;
      bus.req_valid = 1'b0;
      bus.req_op = '0;
      bus.req_addr = '0;
      bus.req_wdata = '0;
      for (int i = 0; i < 64; i++) begin
         w = i == 4 ? 32'h8899_AABB : $urandom;
         @(negedge clk);
         init_we = 1'b1;
         init_idx = 6'(i);
         init_data = w;
         for (int j = 0; j < 4; j++) ref_b[4*i+j] = w[8*j +: 8];
      end
      @(negedge clk);
      init_we = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
      chk("rst_resp_error", {31'd0, bus.resp_error}, 32'd0);
      chk("rst_mem_address", bus.mem_address, 32'd0);
      chk("rst_mem_wdata", bus.mem_write_data, 32'd0);
      chk("rst_mem_en", {30'd0, bus.mem_read_enable, bus.mem_write_enable}, 32'd0);
      rst_n = 1'b1;
      issue(4'b0000, 8'h11, 32'h0, 1'b1);
      issue(4'b0100, 8'h11, 32'h0, 1'b1);
      drain();
      r0 = n_rd;
      w0 = n_wr;
      issue(4'b1001, 8'h12, 32'h0000_1234, 1'b1);
      drain();
      chk("sh_reads", n_rd - r0, 32'd1);
      chk("sh_writes", n_wr - w0, 32'd1);
      chk("sh_waddr", last_wa, 32'h10);
      chk("sh_wdata", last_wd, 32'h1234_AABB);
      issue(4'b0010, 8'h10, 32'h0, 1'b1);
      drain();
      r0 = n_rd;
      w0 = n_wr;
      issue(4'b1010, 8'h20, 32'hDEAD_BEEF, 1'b1);
      drain();
      chk("sw_reads", n_rd - r0, 32'd0);
      chk("sw_writes", n_wr - w0, 32'd1);
      chk("sw_waddr", last_wa, 32'h20);
      chk("sw_wdata", last_wd, 32'hDEAD_BEEF);
      r0 = n_rd;
      w0 = n_wr;
      issue(4'b0001, 8'h13, 32'h0, 1'b1);
      drain();
`ifdef MISALIGN_TRAP_EN
      chk("lh13_reads", n_rd - r0, 32'd0);
`else
      chk("lh13_reads", n_rd - r0, 32'd1);
`endif
      chk("lh13_writes", n_wr - w0, 32'd0);
      w0 = n_wr;
      issue(4'b1000, 8'h31, 32'h0000_005A, 1'b0);
      n = 0;
      while (bus.mem_write_enable !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("midrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("midrst_writes", n_wr - w0, 32'd1);
      chk("midrst_wdata_lane", last_wd[15:8], 32'h5A);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      issue(4'b0110, 8'h30, 32'h0, 1'b1);
      drain();
      for (int k = 0; k < 300; k++) begin
         rnd = $urandom;
         issue(rnd[3:0], 8'($urandom), $urandom, 1'b1);
      end
      drain();
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
